// File: rtl/chipset_pkg.sv
// chipset_pkg: shared state type, enable polarity and sizing helper
// for the chipset READY generator.
package chipset_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT,
        DONE
    } ready_state_t;

    localparam logic CPU_CLK_EN_ACTIVE = 1'b1;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chipset_ready_priority.sv
// chipset_ready_priority: lowest-index channel encoder plus the
// wait-count mux for the selected channel.
module chipset_ready_priority
    import chipset_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WAIT_W   = 4,
    parameter int CH_IDX_W = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]        channel_hit,
    input  logic [NUM_CH*WAIT_W-1:0] channel_wait,
    output logic [CH_IDX_W-1:0]      idx,
    output logic                     hit_valid,
    output logic [WAIT_W-1:0]        wait_sel
);

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        idx      = '0;
        wait_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (channel_hit[i]) begin
                idx      = CH_IDX_W'(i);
                wait_sel = channel_wait[i*WAIT_W +: WAIT_W];
            end
        end
    end

    assign hit_valid = |channel_hit;

endmodule

// File: rtl/chipset_ready_gen.sv
// chipset_ready_gen: CPU RDY generator with per-channel wait states.
// Define CHIPSET_READY_TIMEOUT_EN to add the bus-timeout watchdog.
module chipset_ready_gen
    import chipset_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WAIT_W    = 4,
    parameter int TIMEOUT_W = 8,
    parameter int CH_IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_clock_posedge,
    input  logic                     cpu_clock_negedge,
    input  logic                     ALE,
    input  logic                     IOR_N,
    input  logic                     IOW_N,
    input  logic                     MEMR_N,
    input  logic                     MEMW_N,
    input  logic                     INTA_N,
    input  logic [NUM_CH-1:0]        channel_hit,
    input  logic [NUM_CH*WAIT_W-1:0] channel_wait,
    input  logic [NUM_CH-1:0]        device_ready,
    output logic                     RDY,
    output logic                     timeout_error,
    output logic [CH_IDX_W-1:0]      timeout_channel
);

    ready_state_t        state;
    logic                cmd_active;
    logic                cpu_pe;
    logic                dev_rdy;
    logic                expire;
    logic                unused;
    logic [CH_IDX_W-1:0] sel_idx;
    logic [CH_IDX_W-1:0] ch_lat;
    logic                sel_hit;
    logic                hit_lat;
    logic [WAIT_W-1:0]   sel_wait;
    logic [WAIT_W-1:0]   wait_lat;
    logic [WAIT_W-1:0]   wcnt;
    logic [NUM_CH-1:0]   ready_meta;
    logic [NUM_CH-1:0]   ready_sync;

    chipset_ready_priority #(
        .NUM_CH   (NUM_CH),
        .WAIT_W   (WAIT_W),
        .CH_IDX_W (CH_IDX_W)
    ) u_priority (
        .channel_hit  (channel_hit),
        .channel_wait (channel_wait),
        .idx          (sel_idx),
        .hit_valid    (sel_hit),
        .wait_sel     (sel_wait)
    );

    assign cmd_active = ~(IOR_N & IOW_N & MEMR_N & MEMW_N & INTA_N);
    assign cpu_pe     = (cpu_clock_posedge == CPU_CLK_EN_ACTIVE);
    assign dev_rdy    = ~hit_lat | ready_sync[ch_lat];
    // At 1 or 0 the programmed wait clocks are used up on this edge.
    assign expire     = (wcnt <= WAIT_W'(1));
    assign unused     = cpu_clock_negedge ^ (TIMEOUT_W < 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_meta <= '0;
            ready_sync <= '0;
        end else begin
            ready_meta <= device_ready;
            ready_sync <= ready_meta;
        end
    end

`ifdef CHIPSET_READY_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt;
    logic [TIMEOUT_W-1:0] tcnt_inc;
    logic                 tmo_err;
    logic [CH_IDX_W-1:0]  tmo_ch;

    assign tcnt_inc        = tcnt + 1'b1;
    assign timeout_error   = tmo_err;
    assign timeout_channel = tmo_ch;
`else
    assign timeout_error   = 1'b0;
    assign timeout_channel = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            RDY      <= 1'b1;
            ch_lat   <= '0;
            hit_lat  <= 1'b0;
            wait_lat <= '0;
            wcnt     <= '0;
`ifdef CHIPSET_READY_TIMEOUT_EN
            tcnt     <= '0;
            tmo_err  <= 1'b0;
            tmo_ch   <= '0;
`endif
        end else begin
`ifdef CHIPSET_READY_TIMEOUT_EN
            tmo_err <= 1'b0;
`endif
            if (cpu_pe) begin
                unique case (state)
                    IDLE: begin
                        if (ALE) begin
                            ch_lat   <= sel_idx;
                            hit_lat  <= sel_hit;
                            wait_lat <= sel_wait;
                            state    <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (cmd_active) begin
                            if (wait_lat != '0 || !dev_rdy) begin
                                RDY   <= 1'b0;
                                wcnt  <= wait_lat;
`ifdef CHIPSET_READY_TIMEOUT_EN
                                tcnt  <= '0;
`endif
                                state <= WAIT;
                            end else begin
                                state <= DONE;
                            end
                        end else if (ALE) begin
                            ch_lat   <= sel_idx;
                            hit_lat  <= sel_hit;
                            wait_lat <= sel_wait;
                        end
                    end
                    WAIT: begin
                        if (!cmd_active) begin
                            RDY   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            wcnt <= expire ? '0 : wcnt - 1'b1;
                            if (expire && dev_rdy) begin
                                RDY   <= 1'b1;
                                state <= DONE;
`ifdef CHIPSET_READY_TIMEOUT_EN
                            end else if (&tcnt_inc) begin
                                RDY     <= 1'b1;
                                tmo_err <= 1'b1;
                                tmo_ch  <= ch_lat;
                                state   <= DONE;
                            end else begin
                                tcnt <= tcnt_inc;
`endif
                            end
                        end
                    end
                    DONE: begin
                        if (!cmd_active) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
